whackmole_game_ctrl: RTL and testbench

- Game sequencer for the whack-a-mole datapath: picks a pseudo-random mole, shows it one-hot on LEDR for a bounded window, and judges the player's switch edges.
- Keeps hit/miss/round counters and ends the game after ROUNDS moles.
- Sits between the board switches and LEDs and the score display logic.

---
 rtl/whackmole_game_ctrl.sv | 162 ++++++++++++++++
 tb/tb_whackmole_game_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/whackmole_game_ctrl.sv
// Whack-a-mole game sequencer: lights a pseudo-random mole for a bounded
// window after a dark gap, judges rising switch edges, keeps hit/miss/round
// counts and stops after ROUNDS moles.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begins a game from IDLE or OVER (ignored while busy)
//   SW         switch levels, already synchronised to clk
//   LEDR       one-hot lit mole, 0 when no mole is up
//   hits       correct whacks this game (saturating)
//   misses     timeouts plus wrong whacks this game (saturating)
//   round      moles completed this game
//   busy       high while in GAP or UP
//   game_over  high while in OVER
module whackmole_game_ctrl #(
    parameter int unsigned N_MOLES    = 4,
    parameter int unsigned UP_CYCLES  = 8,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned ROUNDS     = 10,
    parameter int unsigned CNT_W      = 8,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_MOLES-1:0] SW,
    output logic [N_MOLES-1:0] LEDR,
    output logic [CNT_W-1:0]   hits,
    output logic [CNT_W-1:0]   misses,
    output logic [CNT_W-1:0]   round,
    output logic               busy,
    output logic               game_over
);

    localparam int unsigned POS_W   = $clog2(N_MOLES);
    localparam int unsigned MAX_CYC = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
    localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] UP_LOAD  = TMR_W'(UP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_UP   = 2'd2,
        S_OVER = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [N_MOLES-1:0] sw_q;
    logic [CNT_W-1:0]   hits_q, hits_d;
    logic [CNT_W-1:0]   misses_q, misses_d;
    logic [CNT_W-1:0]   round_q, round_d;
    logic [N_MOLES-1:0] ledr_q, ledr_d;
    logic               busy_q, busy_d;
    logic               over_q, over_d;
    logic [N_MOLES-1:0] edge_c;
    logic               judged_c;

    assign edge_c = SW & ~sw_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            pos_q    <= '0;
            lfsr_q   <= LFSR_SEED;
            sw_q     <= '0;
            hits_q   <= '0;
            misses_q <= '0;
            round_q  <= '0;
            ledr_q   <= '0;
            busy_q   <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pos_q    <= pos_d;
            lfsr_q   <= lfsr_d;
            sw_q     <= SW;
            hits_q   <= hits_d;
            misses_q <= misses_d;
            round_q  <= round_d;
            ledr_q   <= ledr_d;
            busy_q   <= busy_d;
            over_q   <= over_d;
        end
    end

    // Next-state, counters and registered outputs
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pos_d    = pos_q;
        hits_d   = hits_q;
        misses_d = misses_q;
        round_d  = round_q;
        judged_c = 1'b0;
        // x^8+x^6+x^5+x^4+1, shifted left with feedback into bit 0
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d  = S_GAP;
                    timer_d  = GAP_LOAD;
                    hits_d   = '0;
                    misses_d = '0;
                    round_d  = '0;
                end
            end
            S_GAP: begin
                if (timer_q == '0) begin
                    state_d = S_UP;
                    pos_d   = POS_W'(32'(lfsr_q) % N_MOLES);
                    timer_d = UP_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_UP: begin
                // A correct edge wins over a simultaneous wrong edge or timeout
                if (edge_c[pos_q]) begin
                    hits_d   = (hits_q == '1) ? hits_q : hits_q + 1'b1;
                    judged_c = 1'b1;
                end else if ((|edge_c) || (timer_q == '0)) begin
                    misses_d = (misses_q == '1) ? misses_q : misses_q + 1'b1;
                    judged_c = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
                if (judged_c) begin
                    round_d = round_q + 1'b1;
                    if (round_d == CNT_W'(ROUNDS)) begin
                        state_d = S_OVER;
                    end else begin
                        state_d = S_GAP;
                        timer_d = GAP_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they align with it
        ledr_d = (state_d == S_UP) ? (N_MOLES'(1) << pos_d) : '0;
        busy_d = (state_d == S_GAP) || (state_d == S_UP);
        over_d = (state_d == S_OVER);
    end

    assign LEDR      = ledr_q;
    assign hits      = hits_q;
    assign misses    = misses_q;
    assign round     = round_q;
    assign busy      = busy_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_whackmole_game_ctrl.sv
// Bench for whackmole_game_ctrl (ROUNDS=3, other parameters default).
// A round-level model predicts mole position, lit window and scores.
module tb_whackmole_game_ctrl;

    localparam int N      = 4;
    localparam int UPC    = 8;
    localparam int GAPC   = 4;
    localparam int NROUND = 3;

    localparam int A_HIT     = 0;
    localparam int A_WRONG   = 1;
    localparam int A_BOTH    = 2;
    localparam int A_TIMEOUT = 3;
    localparam int A_RESET   = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] SW = '0;
    logic [N-1:0] LEDR;
    logic [7:0]   hits, misses, round;
    logic         busy, game_over;

    int n_cmp = 0;
    int n_err = 0;
    int ncyc;
    int m_hits, m_misses, m_round;

    whackmole_game_ctrl #(
        .N_MOLES(N), .UP_CYCLES(UPC), .GAP_CYCLES(GAPC),
        .ROUNDS(NROUND), .CNT_W(8), .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .SW(SW), .LEDR(LEDR),
        .hits(hits), .misses(misses), .round(round),
        .busy(busy), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Edges seen since the last reset = number of LFSR steps taken
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    function automatic logic [7:0] lfsr_after(input int n);
        logic [7:0] v;
        v = 8'hA5;
        for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_scores(input string tag);
        chk({tag, "_hits"},   32'(hits),   32'(m_hits));
        chk({tag, "_misses"}, 32'(misses), 32'(m_misses));
        chk({tag, "_round"},  32'(round),  32'(m_round));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_led"},  32'(LEDR), 32'd0);
        chk({tag, "_hits"}, 32'(hits), 32'd0);
        chk({tag, "_miss"}, 32'(misses), 32'd0);
        chk({tag, "_rnd"},  32'(round), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_over"}, 32'(game_over), 32'd0);
    endtask

    // Called at the negedge right after the edge that entered GAP
    task automatic play_round(input int act, input int dly);
        int pos, other;
        bit done;
        pos = 0;
        for (int g = 0; g < GAPC; g++) begin
            chk("gap_led", 32'(LEDR), 32'd0);
            chk("gap_busy", 32'(busy), 32'd1);
            chk("gap_over", 32'(game_over), 32'd0);
            start = (g < GAPC - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (g == GAPC - 1) pos = int'(lfsr_after(ncyc)) % N;
            tick();
        end
        start = 1'b0;
        other = (pos + int'($urandom_range(1, N - 1))) % N;
        done = 1'b0;
        for (int u = 0; u < UPC && !done; u++) begin
            chk("up_led", 32'(LEDR), 32'(1) << pos);
            chk("up_busy", 32'(busy), 32'd1);
            if (act == A_RESET && u == dly) begin
                #2 rst_n = 1'b0;
                #1 chk_reset_vals("midreset");
                m_hits = 0; m_misses = 0; m_round = 0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (act != A_TIMEOUT && u == dly) begin
                case (act)
                    A_HIT:   SW = N'(1) << pos;
                    A_WRONG: SW = N'(1) << other;
                    default: SW = (N'(1) << pos) | (N'(1) << other);
                endcase
                done = 1'b1;
            end
            tick();
        end
        SW = '0;
        if (act == A_HIT || act == A_BOTH) m_hits++;
        else m_misses++;
        m_round++;
        chk("post_led", 32'(LEDR), 32'd0);
        chk_scores("post");
        chk("post_busy", 32'(busy), 32'(m_round < NROUND));
        chk("post_over", 32'(game_over), 32'(m_round == NROUND));
    endtask

    task automatic start_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_hits = 0; m_misses = 0; m_round = 0;
    endtask

    task automatic hold_over();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("over_led", 32'(LEDR), 32'd0);
            chk("over_flag", 32'(game_over), 32'd1);
            chk("over_busy", 32'(busy), 32'd0);
            chk_scores("over_hold");
        end
    endtask

    task automatic random_game();
        start_game();
        for (int r = 0; r < NROUND; r++)
            play_round(int'($urandom_range(0, 3)), int'($urandom_range(0, UPC - 1)));
        hold_over();
    endtask

    initial begin
        m_hits = 0; m_misses = 0; m_round = 0;
        // Reset with all switches held high
        SW = '1;
        #2 rst_n = 1'b0;
        #2 chk_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_reset_vals("idle_held_sw");
        end
        SW = '0;
        tick();

        // Hit, timeout, hit -> game over with 2/1/3
        start_game();
        play_round(A_HIT, 2);
        play_round(A_TIMEOUT, 0);
        play_round(A_HIT, int'($urandom_range(0, UPC - 1)));
        chk("g1_hits", 32'(hits), 32'd2);
        chk("g1_misses", 32'(misses), 32'd1);
        chk("g1_round", 32'(round), 32'd3);
        hold_over();

        // Wrong whack, lit+wrong together, then random
        start_game();
        chk_scores("restart_clear");
        play_round(A_WRONG, int'($urandom_range(0, UPC - 1)));
        play_round(A_BOTH, int'($urandom_range(0, UPC - 1)));
        play_round(int'($urandom_range(0, 3)), int'($urandom_range(0, UPC - 1)));
        hold_over();

        // Last-cycle hit beats the timeout
        start_game();
        play_round(A_HIT, UPC - 1);
        play_round(A_BOTH, UPC - 1);
        play_round(A_WRONG, UPC - 1);
        hold_over();

        random_game();

        // Reset during UP with two hits banked
        start_game();
        play_round(A_HIT, int'($urandom_range(0, UPC - 1)));
        play_round(A_HIT, int'($urandom_range(0, UPC - 1)));
        chk("pre_reset_hits", 32'(hits), 32'd2);
        play_round(A_RESET, int'($urandom_range(0, UPC - 1)));
        chk_reset_vals("after_release");
        tick();
        tick();

        // LFSR restarts from seed: mole positions follow the model again
        random_game();
        random_game();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
